// File: rtl/wam_pkg.sv
// Shared types and helpers for the whack-a-mole hit stage: hole count,
// packed BCD score type, popcount and saturating BCD add.
package wam_pkg;

  localparam int N_HOLES = 8;
  localparam logic [7:0] BCD_MAX = 8'h99;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_t;

  function automatic logic [3:0] popcount(input logic [N_HOLES-1:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < N_HOLES; i++) begin
      c = c + {3'd0, v[i]};
    end
    return c;
  endfunction

  // k is at most 8, so a single carry into tens is enough; past 99 the value pins at BCD_MAX
  function automatic bcd_t bcd_sat_add(input bcd_t a, input logic [3:0] k);
    logic [4:0] ones_v;
    logic [4:0] tens_v;
    bcd_t       r;
    ones_v = {1'b0, a.ones} + {1'b0, k};
    tens_v = {1'b0, a.tens};
    if (ones_v >= 5'd10) begin
      ones_v = ones_v - 5'd10;
      tens_v = tens_v + 5'd1;
    end else begin
      ones_v = ones_v;
    end
    if (tens_v >= 5'd10) begin
      r = bcd_t'(BCD_MAX);
    end else begin
      r.tens = tens_v[3:0];
      r.ones = ones_v[3:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/wam_debounce.sv
// One button: 2-FF synchroniser, persistence-count debouncer and
// rising-edge detector on the debounced level.
import wam_pkg::*;

module wam_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk_19,
  input  logic clr,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  logic          s1_r;
  logic          s2_r;
  logic          db_r;
  logic          db_d_r;
  logic [CW-1:0] cnt_r;

  // Synchroniser, debounce counter and delayed level; any agreement restarts the count
  always_ff @(posedge clk_19 or posedge clr) begin
    if (clr) begin
      s1_r   <= 1'b0;
      s2_r   <= 1'b0;
      db_r   <= 1'b0;
      db_d_r <= 1'b0;
      cnt_r  <= CNT_ZERO;
    end else begin
      s1_r   <= btn;
      s2_r   <= s1_r;
      db_d_r <= db_r;
      if (s2_r == db_r) begin
        cnt_r <= CNT_ZERO;
      end else if (cnt_r == CNT_LAST) begin
        db_r  <= s2_r;
        cnt_r <= CNT_ZERO;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  assign press = db_r & ~db_d_r;

endmodule

// File: rtl/wam_hit.sv
// Hole-button front end: debounced presses become one-cycle hit pulses
// on occupied holes, with saturating BCD hit and miss counters.
import wam_pkg::*;

module wam_hit #(
  parameter int DB_CYCLES = 4
) (
  input  logic               clk_19,
  input  logic               clr,
  input  logic [N_HOLES-1:0] btn,
  input  logic [N_HOLES-1:0] holes,
  input  logic               run,
  output logic [N_HOLES-1:0] hit,
  output logic [7:0]         score,
  output logic [7:0]         miss
);

  logic [N_HOLES-1:0] press_s;
  logic [N_HOLES-1:0] hit_r;
  logic [3:0]         k_s;
  logic [3:0]         m_s;
  bcd_t               score_r;
  bcd_t               miss_r;

  for (genvar gi = 0; gi < N_HOLES; gi++) begin : g_btn
    wam_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .clk_19(clk_19),
      .clr   (clr),
      .btn   (btn[gi]),
      .press (press_s[gi])
    );
  end

  // Per-cycle hit and miss counts; presses while not running are dropped
  always_comb begin
    k_s = 4'd0;
    m_s = 4'd0;
    if (run) begin
      k_s = popcount(press_s & holes);
      m_s = popcount(press_s & ~holes);
    end else begin
      k_s = 4'd0;
      m_s = 4'd0;
    end
  end

  // Hit pulse and counters update together on the edge after the press
  always_ff @(posedge clk_19 or posedge clr) begin
    if (clr) begin
      hit_r   <= {N_HOLES{1'b0}};
      score_r <= bcd_t'(8'h00);
      miss_r  <= bcd_t'(8'h00);
    end else begin
      hit_r   <= press_s & holes & {N_HOLES{run}};
      score_r <= bcd_sat_add(score_r, k_s);
      miss_r  <= bcd_sat_add(miss_r, m_s);
    end
  end

  assign hit   = hit_r;
  assign score = score_r;
  assign miss  = miss_r;

endmodule
